calc_ctrl: RTL
==============

# calc_ctrl

Sequencing controller for the calculator's 4-entry × 3-bit register file. It accepts one calculator command at a time over a valid/ready handshake and drives the register file's read and write ports. It performs the 3-bit ALU operation internally and returns the result and a carry/borrow flag over a second valid/ready handshake. It sits between the command source (keypad decoder or host) and the register file.

## Interface
Parameters:
- None; widths are fixed at a 3-bit data path and 2-bit register addresses.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  3  opcode: 000 LDI, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MOV, 111 RD.
- cmd_dst  in  2  destination register.
- cmd_srca  in  2  operand A register.
- cmd_srcb  in  2  operand B register.
- cmd_imm  in  3  immediate value for LDI.
- rf_rea, rf_reb  out  1 each  register file read enables.
- rf_raa, rf_rab  out  2 each  register file read addresses.
- rf_douta, rf_doutb  in  3 each  register file read data; combinational, valid in the same cycle as the read enable.
- rf_we  out  1  register file write enable.
- rf_wa  out  2  register file write address.
- rf_din  out  3  register file write data.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  3  operation result.
- res_flag  out  1  carry for ADD, borrow for SUB, 0 for all other ops.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → READ → EXEC → WB → DONE → IDLE. All ops follow the same path, giving a fixed latency.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, dst, srca, srcb and imm; go to READ.
- READ:
  - rf_raa=srca, rf_rab=srcb.
  - rf_rea=1 for all ops except LDI.
  - rf_reb=1 for ADD, SUB, AND, OR and XOR.
  - At the clock edge, capture rf_douta/rf_doutb into operand registers A and B.
  - A port whose enable is low returns 0 from the register file, so its operand captures 0.
- EXEC: compute the 3-bit result and flag into result registers.
  - LDI: imm.
  - ADD: (A+B) mod 8; flag = bit 3 of the 4-bit sum.
  - SUB: (A−B) mod 8; flag = (A<B).
  - AND/OR/XOR: bitwise; flag = 0.
  - MOV and RD: A; flag = 0.
- WB:
  - rf_wa=dst, rf_din=result.
  - rf_we=1 for every op except RD, so the register file writes at the end of WB.
- DONE:
  - res_valid=1, with res_data/res_flag held stable.
  - Advance to IDLE on res_valid&&res_ready; otherwise remain in DONE.
- Outside their own states, all rf_* outputs are 0. rf_we is high only in WB.
- Commands are strictly serialized, so there is no read-after-write hazard: WB completes before the next READ.
- srca, srcb and dst may all be equal. Operands are captured in READ, so ADD r1=r1+r1 uses the old r1.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - cmd_ready=1; busy=0; res_valid=0; res_data=0; res_flag=0.
  - All rf_* outputs are 0.
  - Latched fields and operand/result registers are cleared to 0.
  - Register file contents are not affected.
- Reset asserted mid-operation aborts the command. If it arrives during WB, rf_we drops before the next edge, so no write occurs. Reset deasserted mid-cycle takes effect at the next edge.
- Latency: handshake at edge N; READ in cycle N+1; EXEC in N+2; WB in N+3 (write at edge N+4); res_valid high from N+4.
- Throughput: with res_ready tied high, one command every 5 cycles. The next cmd_ready rises in the cycle after the result handshake.
- cmd_valid is ignored outside IDLE. The command fields only need to be stable in the handshake cycle.
- res_valid, once high, stays high with stable data until res_ready is sampled high.

## Test plan
- Reset then LDI r1=5, LDI r2=3 -> each gives res_data 5 / 3 with flag 0, rf_we pulsed exactly one cycle at rf_wa 1 / 2; res_valid occurs 4 cycles after accept.
- ADD r0=r1+r2 -> res_data 0, res_flag 1, RF r0=0. Then SUB r3=r2−r1 -> res_data 6, res_flag 1. Then SUB r3=r1−r2 -> 2, flag 0.
- RD r3 (after r3=2) -> res_data 2, rf_we never asserted, rf_reb stays 0.
- Backpressure: hold res_ready=0 for 3 cycles in DONE -> res_valid and res_data stable, cmd_ready=0 throughout, and a cmd_valid presented meanwhile is not accepted.
- Aliasing: with r1=5, ADD r1=r1+r1 -> res_data 2, flag 1, r1=2. XOR r1=r1^r1 -> 0.
- Assert rst_n low during WB of LDI r0=7 (r0 previously 0) -> rf_we drops immediately, r0 stays 0, and all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/calc_ctrl.sv
// calc_ctrl: serialized command sequencer for a 4x3-bit register file.
// Every command walks IDLE->READ->EXEC->WB->DONE, so latency is fixed.
module calc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_srca,
  input  logic [1:0] cmd_srcb,
  input  logic [2:0] cmd_imm,
  output logic       rf_rea,
  output logic       rf_reb,
  output logic [1:0] rf_raa,
  output logic [1:0] rf_rab,
  input  logic [2:0] rf_douta,
  input  logic [2:0] rf_doutb,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic [2:0] rf_din,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_data,
  output logic       res_flag,
  output logic       busy
);

  localparam logic [2:0] OP_LDI = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_OR  = 3'd4, OP_XOR = 3'd5, OP_MOV = 3'd6, OP_RD  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] op, imm, a, b, res;
  logic [1:0] dst, srca, srcb;
  logic       flag;
  logic [2:0] alu_res;
  logic       alu_flag;
  logic [3:0] sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and all port outputs; rf_* stay 0 outside their own states
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rf_rea    = 1'b0;
    rf_reb    = 1'b0;
    rf_raa    = 2'd0;
    rf_rab    = 2'd0;
    rf_we     = 1'b0;
    rf_wa     = 2'd0;
    rf_din    = 3'd0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_READ;
      end
      S_READ: begin
        rf_raa    = srca;
        rf_rab    = srcb;
        rf_rea    = (op != OP_LDI);
        rf_reb    = (op >= OP_ADD) && (op <= OP_XOR);
        state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        rf_wa     = dst;
        rf_din    = res;
        rf_we     = (op != OP_RD);
        state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign res_data = res;
  assign res_flag = flag;

  // 3-bit ALU over the captured operands
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    alu_res  = 3'd0;
    alu_flag = 1'b0;
    case (op)
      OP_LDI: alu_res = imm;
      OP_ADD: begin alu_res = sum[2:0]; alu_flag = sum[3]; end
      OP_SUB: begin alu_res = a - b;    alu_flag = (a < b); end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      default: alu_res = a;              // MOV, RD
    endcase
  end

  // Command latch, operand capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op   <= 3'd0;
      imm  <= 3'd0;
      dst  <= 2'd0;
      srca <= 2'd0;
      srcb <= 2'd0;
      a    <= 3'd0;
      b    <= 3'd0;
      res  <= 3'd0;
      flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          op   <= cmd_op;
          imm  <= cmd_imm;
          dst  <= cmd_dst;
          srca <= cmd_srca;
          srcb <= cmd_srcb;
        end
        // Disabled read ports return 0, so unused operands capture 0
        S_READ: begin
          a <= rf_douta;
          b <= rf_doutb;
        end
        S_EXEC: begin
          res  <= alu_res;
          flag <= alu_flag;
        end
        default: ;
      endcase
    end
  end

endmodule
